led_step_sched: RTL and testbench
=================================

LED_STEP_SCHED -- requirements
Module: led_step_sched

Interface
REQ-001 Parameter CNT_W, 32: width of the shared step counter.
REQ-002 Parameter LEN_W, 8: width of each requester's run-length field.
REQ-003 Parameter LED_W, 8: width of the LED output; SHALL be less than or equal to CNT_W.
REQ-004 CLK  in  1  clock; all state SHALL update on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  2  per-requester run request; bit i belongs to requester i.
REQ-007 req_ready  out  2  per-requester grant/accept strobe.
REQ-008 req_len0  in  LEN_W  number of counter steps requested by requester 0.
REQ-009 req_len1  in  LEN_W  number of counter steps requested by requester 1.
REQ-010 hold  in  1  pause; RUN SHALL not advance while hold is high.
REQ-011 cnt  out  CNT_W  shared step counter value.
REQ-012 LED  out  LED_W  LED drive, SHALL equal cnt[LED_W-1:0] at all times.
REQ-013 busy  out  1  high in RUN and DONE.
REQ-014 owner  out  1  index of the requester currently served; valid while busy is high.
REQ-015 done  out  2  one-cycle completion pulse per requester.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-017 IDLE arbitration: req_ready SHALL be one-hot or zero; bit i SHALL be high only when the state is IDLE, req_valid[i] is high, and i wins arbitration.
REQ-018 Arbitration: a sole valid requester SHALL win. When both are valid, the winner SHALL be the requester not served most recently (round-robin pointer rr). Out of reset, requester 0 SHALL win a tie.
REQ-019 Accept cycle T is the cycle in which req_valid[i] and req_ready[i] are both high. At T the block SHALL latch remain = req_len[i] and owner = i. If req_len[i] is nonzero, the next state SHALL be RUN; if it is zero, the next state SHALL be DONE.
REQ-020 RUN: in each cycle with hold low, cnt SHALL increment by 1 and remain SHALL decrement by 1. When remain equals 1 and hold is low, the next state SHALL be DONE.
REQ-021 RUN with hold high: cnt and remain SHALL hold their values and the state SHALL remain RUN.
REQ-022 Latency: with no hold, len N≥1 accepted at T SHALL increment cnt on cycles T+1 through T+N, assert done[owner] at T+N+1, and return to IDLE at T+N+2.
REQ-023 Zero length: len 0 accepted at T SHALL leave cnt unchanged and assert done[owner] at T+1.
REQ-024 DONE SHALL last exactly one cycle. During DONE, done[owner] SHALL be high, rr SHALL be set to owner, and the next state SHALL be IDLE.
REQ-025 The earliest re-accept SHALL be the cycle after DONE. A still-asserted req_valid SHALL be re-arbitrated at that point.
REQ-026 cnt SHALL wrap modulo 2^CNT_W (all-ones + 1 = 0) and SHALL otherwise hold its value in IDLE and DONE. cnt SHALL never reset between runs.
REQ-027 req_len and req_valid SHALL be ignored outside the IDLE state; deasserting req_valid during RUN SHALL not abort the run.
REQ-028 hold in IDLE or DONE SHALL have no effect.

Reset
REQ-029 When RST is high at a clock edge, the block SHALL set: state IDLE, cnt 0, LED 0, remain 0, owner 0, rr favouring requester 0, busy 0, req_ready 0, done 0.
REQ-030 RST asserted mid-RUN SHALL abort the run with no done pulse. RST SHALL take priority over every other input.

Verification
REQ-031 Single run: reset, then req_valid=01 with req_len0=5. Required: req_ready=01 for one cycle; cnt 0→5 over 5 cycles; done=01 one cycle later; busy low after.
REQ-032 Tie and rotation: both req_valid held, req_len0=2, req_len1=3. Required: requester 0 served first (cnt→2, done=01), then requester 1 (cnt→5, done=10), then requester 0 again.
REQ-033 Hold: req_len1=4 with hold high for 3 cycles mid-run. Required: cnt frozen during hold; done=10 arrives exactly 3 cycles later than the no-hold case.
REQ-034 Zero length and wrap: preload cnt to 0xFFFFFFFE via runs, then issue len 0. Required: done pulse at T+1 and cnt unchanged. Then issue len 3. Required: cnt sequence FFFFFFFF, 00000000, 00000001; LED=01.
REQ-035 Reset mid-run: RST asserted on the 2nd RUN cycle of a len=10 run. Required: next cycle cnt=0, busy=0, done=00, and no done pulse ever issued for the aborted run.

Source files
------------

// File: rtl/led_step_sched_if.sv
// led_step_sched_if: request/run handshake and status bundle for led_step_sched
interface led_step_sched_if #(parameter int CNT_W = 32, parameter int LEN_W = 8, parameter int LED_W = 8);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [LEN_W-1:0] req_len0;
  logic [LEN_W-1:0] req_len1;
  logic             hold;
  logic [CNT_W-1:0] cnt;
  logic [LED_W-1:0] LED;
  logic             busy;
  logic             owner;
  logic [1:0]       done;
  modport master(output req_valid, req_len0, req_len1, hold, input req_ready, cnt, LED, busy, owner, done);
  modport slave(input req_valid, req_len0, req_len1, hold, output req_ready, cnt, LED, busy, owner, done);
endinterface

// File: rtl/led_step_sched.sv
// led_step_sched: two-requester round-robin scheduler stepping a shared counter that drives the LEDs
module led_step_sched #(parameter int CNT_W = 32, parameter int LEN_W = 8, parameter int LED_W = 8) (
  input logic CLK,
  input logic RST,
  led_step_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [LEN_W-1:0] remain;
  logic [LEN_W-1:0] len_sel;
  logic owner_q, rr, win;
  logic [1:0] grant;
  // rr holds the last served requester; resetting it to 1 makes requester 0 win the first tie
  always_comb begin
    win = (bus.req_valid == 2'b11) ? ~rr : bus.req_valid[1];
    grant = (state == IDLE && !RST && bus.req_valid != 2'b00) ? (win ? 2'b10 : 2'b01) : 2'b00;
    len_sel = win ? bus.req_len1 : bus.req_len0;
  end
  always_ff @(posedge CLK)
    if (RST) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) state_nxt = (grant != 2'b00) ? ((len_sel != '0) ? RUN : DONE) : IDLE;
    else if (state == RUN) state_nxt = (!bus.hold && remain == LEN_W'(1)) ? DONE : RUN;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      cnt_q <= '0;
      remain <= '0;
      owner_q <= 1'b0;
      rr <= 1'b1;
    end else begin
      if (grant != 2'b00) begin
        remain <= len_sel;
        owner_q <= win;
      end
      if (state == RUN && !bus.hold) begin
        cnt_q <= cnt_q + CNT_W'(1);
        remain <= remain - LEN_W'(1);
      end
      if (state == DONE) rr <= owner_q;
    end
  always_comb begin
    bus.req_ready = grant;
    bus.cnt = cnt_q;
    bus.LED = cnt_q[LED_W-1:0];
    bus.busy = (state != IDLE);
    bus.owner = owner_q;
    bus.done = (state == DONE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  end
endmodule

// File: tb/tb_led_step_sched.sv
// tb_led_step_sched: directed checks of arbitration, run timing, hold, zero length, wrap and reset abort
module tb_led_step_sched;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 CLK = ~CLK;
  led_step_sched_if #(.CNT_W(32), .LEN_W(8), .LED_W(8)) b();
  // an 8-bit counter instance lets the wrap case be reached within a short run
  led_step_sched_if #(.CNT_W(8), .LEN_W(8), .LED_W(8)) bw();
  led_step_sched #(.CNT_W(32), .LEN_W(8), .LED_W(8)) dut (.CLK(CLK), .RST(RST), .bus(b));
  led_step_sched #(.CNT_W(8), .LEN_W(8), .LED_W(8)) dut_w (.CLK(CLK), .RST(RST), .bus(bw));
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    b.req_valid = 2'b00; b.req_len0 = '0; b.req_len1 = '0; b.hold = 1'b0;
    bw.req_valid = 2'b00; bw.req_len0 = '0; bw.req_len1 = '0; bw.hold = 1'b0;
    RST = 1'b1;
    tick; tick;
    tests++; if (b.cnt !== 32'd0) begin fails++; $display("FAIL reset_cnt got %0h exp 0", b.cnt); end
    tests++; if (b.LED !== 8'd0) begin fails++; $display("FAIL reset_led got %0h exp 0", b.LED); end
    tests++; if ({b.busy, b.owner, b.done} !== 4'b0000) begin fails++; $display("FAIL reset_status got %b exp 0000", {b.busy, b.owner, b.done}); end
    tests++; if (bw.cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt_w got %0h exp 0", bw.cnt); end
    b.req_valid = 2'b11;
    #1;
    tests++; if (b.req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got %b exp 00", b.req_ready); end
    b.req_valid = 2'b00;
    RST = 1'b0;
    tick;
  endtask
  task automatic test_single;
    b.req_valid = 2'b01; b.req_len0 = 8'd5;
    #1;
    tests++; if (b.req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b exp 01", b.req_ready); end
    tick;
    b.req_valid = 2'b00;
    #1;
    tests++; if (b.req_ready !== 2'b00) begin fails++; $display("FAIL single_ready_run got %b exp 00", b.req_ready); end
    tests++; if ({b.busy, b.owner, b.cnt} !== {2'b10, 32'd0}) begin fails++; $display("FAIL single_t1 got busy %b owner %b cnt %0h exp 1 0 0", b.busy, b.owner, b.cnt); end
    for (int k = 1; k <= 5; k++) begin
      tick;
      tests++; if (b.cnt !== 32'(k)) begin fails++; $display("FAIL single_cnt got %0h exp %0h", b.cnt, k); end
      tests++; if (b.done !== ((k == 5) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL single_done step %0d got %b exp %b", k, b.done, (k == 5) ? 2'b01 : 2'b00); end
    end
    tick;
    tests++; if ({b.busy, b.done} !== 3'b000) begin fails++; $display("FAIL single_idle got %b exp 000", {b.busy, b.done}); end
  endtask
  task automatic test_tie;
    RST = 1'b1;
    tick;
    RST = 1'b0;
    b.req_valid = 2'b11; b.req_len0 = 8'd2; b.req_len1 = 8'd3;
    #1;
    tests++; if (b.req_ready !== 2'b01) begin fails++; $display("FAIL tie_first got %b exp 01", b.req_ready); end
    tick;
    tests++; if (b.req_ready !== 2'b00) begin fails++; $display("FAIL tie_ready_run got %b exp 00", b.req_ready); end
    tick; tick;
    tests++; if ({b.done, b.cnt} !== {2'b01, 32'd2}) begin fails++; $display("FAIL tie_done0 got done %b cnt %0h exp 01 2", b.done, b.cnt); end
    tick;
    tests++; if (b.req_ready !== 2'b10) begin fails++; $display("FAIL tie_second got %b exp 10", b.req_ready); end
    tick; tick; tick; tick;
    tests++; if ({b.done, b.cnt} !== {2'b10, 32'd5}) begin fails++; $display("FAIL tie_done1 got done %b cnt %0h exp 10 5", b.done, b.cnt); end
    tick;
    tests++; if (b.req_ready !== 2'b01) begin fails++; $display("FAIL tie_third got %b exp 01", b.req_ready); end
    b.req_valid = 2'b00;
    tick;
  endtask
  task automatic test_hold;
    b.req_valid = 2'b10; b.req_len1 = 8'd4;
    #1;
    tests++; if (b.req_ready !== 2'b10) begin fails++; $display("FAIL hold_ready got %b exp 10", b.req_ready); end
    tick;
    b.req_valid = 2'b00;
    tick;
    tests++; if (b.cnt !== 32'd6) begin fails++; $display("FAIL hold_pre got %0h exp 6", b.cnt); end
    b.hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      tests++; if ({b.cnt, b.done} !== {32'd6, 2'b00}) begin fails++; $display("FAIL hold_frozen got cnt %0h done %b exp 6 00", b.cnt, b.done); end
    end
    b.hold = 1'b0;
    tick;
    tests++; if (b.cnt !== 32'd7) begin fails++; $display("FAIL hold_resume got %0h exp 7", b.cnt); end
    tick;
    tests++; if ({b.cnt, b.done} !== {32'd8, 2'b00}) begin fails++; $display("FAIL hold_early got cnt %0h done %b exp 8 00", b.cnt, b.done); end
    tick;
    tests++; if ({b.cnt, b.done} !== {32'd9, 2'b10}) begin fails++; $display("FAIL hold_done got cnt %0h done %b exp 9 10", b.cnt, b.done); end
    tick;
    tests++; if (b.busy !== 1'b0) begin fails++; $display("FAIL hold_idle got %b exp 0", b.busy); end
  endtask
  task automatic test_reset_mid;
    int pulses;
    b.req_valid = 2'b01; b.req_len0 = 8'd10;
    tick;
    b.req_valid = 2'b00;
    tick;
    tests++; if ({b.busy, b.cnt} !== {1'b1, 32'd10}) begin fails++; $display("FAIL mid_run got busy %b cnt %0h exp 1 a", b.busy, b.cnt); end
    RST = 1'b1;
    tick;
    RST = 1'b0;
    tests++; if ({b.busy, b.done, b.cnt} !== {3'b000, 32'd0}) begin fails++; $display("FAIL mid_abort got busy %b done %b cnt %0h exp 0 00 0", b.busy, b.done, b.cnt); end
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      tick;
      if (b.done !== 2'b00) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL mid_no_done got %0d pulses exp 0", pulses); end
  endtask
  task automatic test_zero_wrap;
    bw.req_valid = 2'b01; bw.req_len0 = 8'd254;
    tick;
    bw.req_valid = 2'b00;
    for (int i = 0; i < 300 && bw.done === 2'b00; i++) tick;
    tests++; if ({bw.done, bw.cnt} !== {2'b01, 8'hFE}) begin fails++; $display("FAIL wrap_preload got done %b cnt %0h exp 01 fe", bw.done, bw.cnt); end
    tick;
    bw.req_valid = 2'b01; bw.req_len0 = 8'd0;
    #1;
    tests++; if (bw.req_ready !== 2'b01) begin fails++; $display("FAIL zero_ready got %b exp 01", bw.req_ready); end
    tick;
    bw.req_valid = 2'b00;
    tests++; if ({bw.busy, bw.done, bw.cnt} !== {3'b101, 8'hFE}) begin fails++; $display("FAIL zero_done got busy %b done %b cnt %0h exp 1 01 fe", bw.busy, bw.done, bw.cnt); end
    tick;
    tests++; if ({bw.busy, bw.cnt} !== {1'b0, 8'hFE}) begin fails++; $display("FAIL zero_after got busy %b cnt %0h exp 0 fe", bw.busy, bw.cnt); end
    bw.req_valid = 2'b01; bw.req_len0 = 8'd3;
    tick;
    bw.req_valid = 2'b00;
    tick;
    tests++; if (bw.cnt !== 8'hFF) begin fails++; $display("FAIL wrap_ff got %0h exp ff", bw.cnt); end
    tick;
    tests++; if (bw.cnt !== 8'h00) begin fails++; $display("FAIL wrap_00 got %0h exp 00", bw.cnt); end
    tick;
    tests++; if ({bw.cnt, bw.LED, bw.done} !== {8'h01, 8'h01, 2'b01}) begin fails++; $display("FAIL wrap_01 got cnt %0h led %0h done %b exp 01 01 01", bw.cnt, bw.LED, bw.done); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_tie;
    test_hold;
    test_reset_mid;
    test_zero_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
